booth_multiplier_32: RTL and testbench

Signed 32x32 -> 64-bit multiplier built on a radix-4 (modified) Booth recoder with a partial-product adder tree. It provides a combinational product and a one-stage registered product with a valid flag. It is the Booth member of the multiplier comparison set and must match the array, Dadda and sequential multipliers bit-for-bit on every input.

---
 rtl/booth_multiplier_32.sv | 129 ++++++++++++
 tb/tb_booth_multiplier_32.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_32.sv
// booth_multiplier_32: signed WIDTH x WIDTH -> 2*WIDTH multiplier using radix-4 (modified)
// Booth recoding of the multiplier, carry-save reduction of the partial products and a
// single final carry-propagate adder. The combinational product is also captured into a
// one-stage output register qualified by in_valid.
//
// Ports:
//   clk          rising-edge clock for the output register stage
//   rst_n        asynchronous active-low reset (clears product and out_valid)
//   in_valid     qualifies multiplicand/multiplier for capture into the output stage
//   multiplicand signed two's-complement operand A
//   multiplier   signed two's-complement operand B (Booth-recoded)
//   product_comb combinational signed A*B
//   product      registered signed A*B
//   out_valid    product holds the result of a captured in_valid cycle
module booth_multiplier_32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product_comb,
   output logic [2*WIDTH-1:0]   product,
   output logic                 out_valid
);

   localparam int unsigned PW    = 2 * WIDTH;   // product width
   localparam int unsigned XW    = WIDTH + 2;   // A extended so that 2*(-2^(W-1)) fits
   localparam int unsigned NumPp = WIDTH / 2;   // one radix-4 digit per two multiplier bits

   // ------------------------------------------------------------------------
   // Operand extension
   // ------------------------------------------------------------------------
   logic [XW-1:0]    a_x;
   logic [WIDTH+2:0] b_x;   // {sign, sign, B, 0}: implicit 0 below B[0]

   assign a_x = {{2{multiplicand[WIDTH-1]}}, multiplicand};
   assign b_x = {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};

   // ------------------------------------------------------------------------
   // Booth digit selection and partial-product generation
   // ------------------------------------------------------------------------
   logic [PW-1:0] pp [NumPp];
   logic [PW-1:0] corr;       // +1 completion bits for negated rows

   always_comb begin : p_pp
      logic [2:0]    grp;
      logic [XW-1:0] mag;
      logic [XW-1:0] row;
      logic          neg;
      corr = '0;
      for (int i = 0; i < NumPp; i++) begin
         grp = b_x[2*i +: 3];
         mag = '0;
         neg = 1'b0;
         case (grp)
            3'b001, 3'b010: mag = a_x;
            3'b011:         mag = a_x << 1;
            3'b100: begin
               mag = a_x << 1;
               neg = 1'b1;
            end
            3'b101, 3'b110: begin
               mag = a_x;
               neg = 1'b1;
            end
            default:        mag = '0;   // 000 / 111 -> digit 0
         endcase
         // Negation is one's complement here; the +1 lands in corr at weight 2^(2i).
         row       = neg ? ~mag : mag;
         pp[i]     = {{(PW-XW){row[XW-1]}}, row} << (2 * i);
         corr[2*i] = neg;
      end
   end

   // ------------------------------------------------------------------------
   // Carry-save reduction: the correction row seeds the sum vector, then each
   // partial product is folded in with a 3:2 compressor row. Carries shifted out
   // of the top bit are discarded, which is exactly modulo 2^PW arithmetic.
   // ------------------------------------------------------------------------
   logic [PW-1:0] cs_sum;
   logic [PW-1:0] cs_carry;

   always_comb begin : p_csa
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      logic [PW-1:0] t;
      s = corr;
      c = '0;
      for (int i = 0; i < NumPp; i++) begin
         t = s ^ c ^ pp[i];
         c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
         s = t;
      end
      cs_sum   = s;
      cs_carry = c;
   end

   assign product_comb = cs_sum + cs_carry;

   // ------------------------------------------------------------------------
   // Output register stage
   // ------------------------------------------------------------------------
   logic [PW-1:0] product_d, product_q;
   logic          out_valid_d, out_valid_q;

   always_comb begin
      product_d   = product_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         product_d = product_comb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign product   = product_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_multiplier_32.sv
// Self-checking bench for booth_multiplier_32: directed literal cases, register/handshake
// and asynchronous-reset sequences, then a randomized regression compared every cycle
// against a plain-arithmetic reference model.
module tb_booth_multiplier_32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [63:0] product_comb;
   logic [63:0] product;
   logic        out_valid;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   booth_multiplier_32 #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product_comb (product_comb),
      .product      (product),
      .out_valid    (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact signed product using 64-bit arithmetic.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Behavioural model of the output register stage.
   logic [63:0] mdl_product = '0;
   logic        mdl_valid   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_product <= '0;
         mdl_valid   <= 1'b0;
      end else begin
         mdl_valid <= in_valid;
         if (in_valid) mdl_product <= ref_mul(multiplicand, multiplier);
      end
   end

   // Compare process: all outputs, every cycle, away from the active edge.
   always @(negedge clk) begin
      check("cmp_product_comb", product_comb, ref_mul(multiplicand, multiplier));
      check("cmp_out_valid", {63'd0, out_valid}, {63'd0, mdl_valid});
      check("cmp_product", product, mdl_product);
   end

   task automatic comb_case(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                            input string name);
      multiplicand = a;
      multiplier   = b;
      #1;
      check(name, product_comb, exp);
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] pick_a;
   logic [31:0] pick_b;

   initial begin
      rst_n        = 1'b1;
      in_valid     = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #1 rst_n = 1'b0;

      // Combinational literal cases (product_comb does not depend on reset).
      comb_case(32'd5,          -32'sd3,      64'hFFFF_FFFF_FFFF_FFF1, "comb_5x-3");
      comb_case(32'd4,          32'd7,        64'd28,                  "comb_4x7");
      comb_case(-32'sd6,        -32'sd4,      64'd24,                  "comb_-6x-4");
      comb_case(-32'sd8,        32'd5,        64'hFFFF_FFFF_FFFF_FFD8, "comb_-8x5");
      comb_case(32'd123,        32'd0,        64'd0,                   "comb_123x0");
      comb_case(32'd456,        32'd1,        64'd456,                 "comb_456x1");
      comb_case(32'd456,        32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FE38, "comb_456x-1");
      comb_case(32'd65536,      32'd65536,    64'h1_0000_0000,         "comb_2^16sq");
      comb_case(32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, "comb_min_sq");
      comb_case(32'h8000_0000,  32'd1,        64'hFFFF_FFFF_8000_0000, "comb_min_x1");
      comb_case(32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "comb_max_sq");
      comb_case(32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "comb_min_x_max");

      // Reset held: outputs stay cleared while clk toggles, even with in_valid high.
      in_valid     = 1'b1;
      multiplicand = 32'd5;
      multiplier   = -32'sd3;
      repeat (3) next_edge();
      check("rst_hold_product", product, 64'd0);
      check("rst_hold_valid", {63'd0, out_valid}, 64'd0);

      // Release mid-cycle; first edge captures (5,-3).
      #2 rst_n = 1'b1;
      next_edge();
      check("hs_valid", {63'd0, out_valid}, 64'd1);
      check("hs_product", product, 64'hFFFF_FFFF_FFFF_FFF1);
      in_valid = 1'b0;
      multiplicand = 32'd99;
      next_edge();
      check("hs_drop_valid", {63'd0, out_valid}, 64'd0);
      check("hs_hold_product", product, 64'hFFFF_FFFF_FFFF_FFF1);

      // Back-to-back captures.
      in_valid = 1'b1;
      multiplicand = 32'd4;
      multiplier   = 32'd7;
      next_edge();
      check("b2b0_valid", {63'd0, out_valid}, 64'd1);
      check("b2b0_product", product, 64'd28);
      multiplicand = -32'sd6;
      multiplier   = -32'sd4;
      next_edge();
      check("b2b1_valid", {63'd0, out_valid}, 64'd1);
      check("b2b1_product", product, 64'd24);
      multiplicand = -32'sd8;
      multiplier   = 32'd5;
      next_edge();
      check("b2b2_valid", {63'd0, out_valid}, 64'd1);
      check("b2b2_product", product, 64'hFFFF_FFFF_FFFF_FFD8);

      // Asynchronous reset between edges clears outputs at once.
      #2 rst_n = 1'b0;
      #1;
      check("arst_product", product, 64'd0);
      check("arst_valid", {63'd0, out_valid}, 64'd0);
      next_edge();
      check("arst_hold_valid", {63'd0, out_valid}, 64'd0);
      #2 rst_n = 1'b1;

      // Randomized regression with occasional extreme operands.
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         #1;
         pick_a = $urandom;
         pick_b = $urandom;
         case ($urandom_range(0, 7))
            0: pick_a = 32'h8000_0000;
            1: pick_b = 32'h7FFF_FFFF;
            2: pick_a = 32'hFFFF_FFFF;
            3: pick_b = 32'h0000_0000;
            default: ;
         endcase
         multiplicand = pick_a;
         multiplier   = pick_b;
         in_valid     = ($urandom_range(0, 3) != 0);
      end
      next_edge();
      in_valid = 1'b0;
      repeat (2) next_edge();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
